// File: rtl/bpug_sequencer_pkg.sv
// Shared definitions for the BPUG sequencer: BPU opcodes, instruction bit positions,
// FSM state encodings and the tag carried alongside each memory read.
package bnn_pkg;

    localparam int unsigned INSTR_W = 10;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_CLR  = 5'd1;
    localparam logic [4:0] OP_CALC = 5'd2;

    localparam int unsigned IDX_DSEL = 5;
    localparam int unsigned IDX_WEN  = 6;
    localparam int unsigned IDX_IEN  = 7;
    localparam int unsigned IDX_UP   = 8;
    localparam int unsigned IDX_ISEL = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_WGT,
        ST_LD_IMG_LO,
        ST_LD_IMG_HI,
        ST_CALC0,
        ST_CALC1,
        ST_SHIFT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_CLR,
        PH_CALC,
        PH_WAIT,
        PH_RES
    } calc_ph_t;

    typedef struct packed {
        logic wen;
        logic ien;
        logic isel;
    } rd_tag_t;

    function automatic logic [INSTR_W-1:0] op_instr(input logic [4:0] op, input logic dsel);
        logic [INSTR_W-1:0] v;
        v           = '0;
        v[4:0]      = op;
        v[IDX_DSEL] = dsel;
        return v;
    endfunction

    function automatic logic [INSTR_W-1:0] load_instr(input rd_tag_t t);
        logic [INSTR_W-1:0] v;
        v           = '0;
        v[IDX_WEN]  = t.wen;
        v[IDX_IEN]  = t.ien;
        v[IDX_ISEL] = t.isel;
        return v;
    endfunction

endpackage

// File: rtl/bpug_sequencer_if.sv
// Bundle of the layer-controller, memory and BPUG-facing signals of the sequencer.
// slave = the sequencer itself, master = whatever drives it.
interface bpug_sequencer_if
    import bnn_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned STEP_W = 8
);
    logic                start;
    logic [ADDR_W-1:0]   wgt_base;
    logic [ADDR_W-1:0]   img_base;
    logic [STEP_W-1:0]   num_steps;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_rd_data;
    logic [7:0]          data_out;
    logic [INSTR_W-1:0]  instruction_out;
    logic                sel_out;
    logic                res_valid;
    logic                res_col;
    logic                busy;
    logic                done;

    modport slave (
        input  start, wgt_base, img_base, num_steps, mem_rd_data,
        output mem_rd_en, mem_addr, data_out, instruction_out, sel_out,
               res_valid, res_col, busy, done
    );

    modport master (
        output start, wgt_base, img_base, num_steps, mem_rd_data,
        input  mem_rd_en, mem_addr, data_out, instruction_out, sel_out,
               res_valid, res_col, busy, done
    );

endinterface

// File: rtl/bpug_sequencer_rd_pipe.sv
// One-stage delay that lines the load enables up with the cycle the read byte
// appears on mem_rd_data.
module bpug_rd_pipe
    import bnn_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_valid,
    input  rd_tag_t i_tag,
    output logic    o_valid,
    output rd_tag_t o_tag
);

    logic    r_valid;
    rd_tag_t r_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
        end else begin
            r_valid <= i_valid;
            r_tag   <= i_tag;
        end
    end

    assign o_valid = r_valid;
    assign o_tag   = r_tag;

endmodule

// File: rtl/bpug_sequencer.sv
// Issues weight/image reads and BPU instructions for one BPUG group: weight load,
// 16-row image window, then num_steps CALC pairs separated by one-row slides.
module bpug_sequencer
    import bnn_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned CALC_LAT  = 2,
    parameter int unsigned WGT_BYTES = 56
)
(
    input  logic              clk,
    input  logic              rst,
    bpug_sequencer_if.slave   bus
);

    localparam int unsigned       CNT_W  = 8;
    localparam logic [CNT_W-1:0]  C_WGT  = CNT_W'(WGT_BYTES);
    localparam logic [CNT_W-1:0]  C_ROWS = CNT_W'(8);
    localparam logic [CNT_W-1:0]  C_LAT1 = CNT_W'(CALC_LAT - 1);

    state_t              r_state;
    calc_ph_t            r_ph;
    logic [CNT_W-1:0]    r_cnt;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   r_nsteps;
    logic [ADDR_W-1:0]   r_iptr;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rd_en;
    rd_tag_t             r_tag;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_sel;
    logic                r_res_valid;
    logic                r_res_col;
    logic                r_busy;
    logic                r_done;

    logic                w_pipe_valid;
    rd_tag_t             w_pipe_tag;
    logic [INSTR_W-1:0]  w_instr;
    logic [STEP_W-1:0]   w_step_nxt;
    logic [CNT_W-1:0]    w_load_len;
    logic                w_calc1;

    bpug_rd_pipe u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_rd_en),
        .i_tag   (r_tag),
        .o_valid (w_pipe_valid),
        .o_tag   (w_pipe_tag)
    );

    assign w_step_nxt = r_step + 1'b1;
    assign w_load_len = (r_state == ST_LD_WGT) ? C_WGT : C_ROWS;
    assign w_calc1    = (r_state == ST_CALC1);

    // Load enables and FSM ops never overlap: loads fully drain before any op cycle.
    always_comb begin
        w_instr = r_instr;
        if (w_pipe_valid) begin
            w_instr = w_instr | load_instr(w_pipe_tag);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ph        <= PH_CLR;
            r_cnt       <= '0;
            r_step      <= '0;
            r_nsteps    <= '0;
            r_iptr      <= '0;
            r_addr      <= '0;
            r_rd_en     <= 1'b0;
            r_tag       <= '0;
            r_instr     <= '0;
            r_sel       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_col   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state  <= ST_LD_WGT;
                        r_busy   <= 1'b1;
                        r_nsteps <= bus.num_steps;
                        r_step   <= '0;
                        r_iptr   <= bus.img_base;
                        r_addr   <= bus.wgt_base;
                        r_rd_en  <= 1'b1;
                        r_cnt    <= CNT_W'(1);
                        r_tag    <= '{wen: 1'b1, ien: 1'b0, isel: 1'b0};
                    end
                end

                ST_LD_WGT, ST_LD_IMG_LO, ST_LD_IMG_HI: begin
                    if (r_rd_en) begin
                        if (r_cnt == w_load_len) begin
                            r_rd_en <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_state == ST_LD_WGT) begin
                                r_addr <= r_addr + 1'b1;
                            end else begin
                                r_addr <= r_iptr;
                                r_iptr <= r_iptr + 1'b1;
                            end
                        end
                    end else begin
                        // Last byte's data cycle: hand over to the next phase.
                        case (r_state)
                            ST_LD_WGT: begin
                                r_state <= ST_LD_IMG_LO;
                                r_rd_en <= 1'b1;
                                r_addr  <= r_iptr;
                                r_iptr  <= r_iptr + 1'b1;
                                r_cnt   <= CNT_W'(1);
                                r_tag   <= '{wen: 1'b0, ien: 1'b1, isel: 1'b0};
                            end
                            ST_LD_IMG_LO: begin
                                r_state <= ST_LD_IMG_HI;
                                r_rd_en <= 1'b1;
                                r_addr  <= r_iptr;
                                r_iptr  <= r_iptr + 1'b1;
                                r_cnt   <= CNT_W'(1);
                                r_tag   <= '{wen: 1'b0, ien: 1'b1, isel: 1'b1};
                            end
                            default: begin
                                if (r_nsteps == '0) begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                    r_busy  <= 1'b0;
                                end else begin
                                    r_state <= ST_CALC0;
                                    r_ph    <= PH_CLR;
                                    r_instr <= op_instr(OP_CLR, 1'b0);
                                end
                            end
                        endcase
                    end
                end

                ST_CALC0, ST_CALC1: begin
                    case (r_ph)
                        PH_CLR: begin
                            r_instr <= op_instr(OP_CALC, w_calc1);
                            r_sel   <= 1'b1;
                            r_ph    <= PH_CALC;
                        end
                        PH_CALC: begin
                            r_instr <= op_instr(OP_NOP, 1'b0);
                            r_sel   <= 1'b0;
                            if (CALC_LAT <= 1) begin
                                r_res_valid <= 1'b1;
                                r_res_col   <= w_calc1;
                                r_ph        <= PH_RES;
                            end else begin
                                r_cnt <= CNT_W'(1);
                                r_ph  <= PH_WAIT;
                            end
                        end
                        PH_WAIT: begin
                            if (r_cnt == C_LAT1) begin
                                r_res_valid <= 1'b1;
                                r_res_col   <= w_calc1;
                                r_ph        <= PH_RES;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        default: begin
                            r_res_valid <= 1'b0;
                            r_res_col   <= 1'b0;
                            r_ph        <= PH_CLR;
                            if (!w_calc1) begin
                                r_state <= ST_CALC1;
                                r_instr <= op_instr(OP_CLR, 1'b0);
                            end else begin
                                r_step <= w_step_nxt;
                                if (w_step_nxt == r_nsteps) begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                    r_busy  <= 1'b0;
                                end else begin
                                    r_state          <= ST_SHIFT;
                                    r_instr          <= '0;
                                    r_instr[IDX_UP]  <= 1'b1;
                                    r_sel            <= 1'b1;
                                end
                            end
                        end
                    endcase
                end

                ST_SHIFT: begin
                    r_instr <= '0;
                    r_sel   <= 1'b0;
                    r_state <= ST_LD_IMG_HI;
                    r_rd_en <= 1'b1;
                    r_addr  <= r_iptr;
                    r_iptr  <= r_iptr + 1'b1;
                    r_cnt   <= CNT_W'(1);
                    r_tag   <= '{wen: 1'b0, ien: 1'b1, isel: 1'b1};
                end

                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd_en       = r_rd_en;
    assign bus.mem_addr        = r_addr;
    assign bus.data_out        = bus.mem_rd_data;
    assign bus.instruction_out = w_instr;
    assign bus.sel_out         = r_sel | (w_pipe_valid & w_pipe_tag.wen);
    assign bus.res_valid       = r_res_valid;
    assign bus.res_col         = r_res_col;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;

endmodule

// File: tb/tb_bpug_sequencer.sv
// Directed bench for bpug_sequencer: memory returns the low address byte, a
// negedge monitor logs reads, data-cycle instructions, op cycles and results.
module tb_bpug_sequencer;
    import bnn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   st_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bpug_sequencer_if #(.ADDR_W(16), .STEP_W(8)) bus ();

    bpug_sequencer #(.ADDR_W(16), .STEP_W(8), .CALC_LAT(2), .WGT_BYTES(56)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (rst) bus.mem_rd_data <= 8'h00;
        else     bus.mem_rd_data <= bus.mem_rd_en ? bus.mem_addr[7:0] : 8'h00;
    end

    logic [7:0] wgt [56];
    always @(posedge clk) begin
        if (bus.instruction_out[IDX_WEN]) begin
            for (int i = 0; i < 55; i++) wgt[i] <= wgt[i+1];
            wgt[55] <= bus.data_out;
        end
    end

    logic [15:0] rd_q [$];
    logic [10:0] dat_q [$];
    logic [7:0]  dval_q [$];
    logic [10:0] ctl_q [$];
    int          ctl_rel_q [$];
    logic        res_q [$];
    int          res_rel_q [$];
    int          done_rel_q [$];
    int          viol = 0;
    logic        prev_rd = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_rd_en) rd_q.push_back(bus.mem_addr);
        if (prev_rd) begin
            dat_q.push_back({bus.sel_out, bus.instruction_out});
            dval_q.push_back(bus.data_out);
        end else if (bus.sel_out || bus.instruction_out != '0) begin
            ctl_q.push_back({bus.sel_out, bus.instruction_out});
            ctl_rel_q.push_back(cyc - st_cyc + 1);
        end
        if (bus.res_valid) begin
            res_q.push_back(bus.res_col);
            res_rel_q.push_back(cyc - st_cyc + 1);
        end
        if (bus.done) done_rel_q.push_back(cyc - st_cyc + 1);
        if ((bus.instruction_out[IDX_IEN] && bus.instruction_out[IDX_UP]) ||
            (bus.instruction_out[IDX_IEN] && bus.instruction_out[IDX_WEN])) viol++;
        prev_rd = bus.mem_rd_en;
    end

    task automatic clear_logs();
        rd_q.delete(); dat_q.delete(); dval_q.delete(); ctl_q.delete(); ctl_rel_q.delete();
        res_q.delete(); res_rel_q.delete(); done_rel_q.delete(); viol = 0;
    endtask

    task automatic kick(input logic [15:0] wb, input logic [15:0] ib, input logic [7:0] ns);
        @(posedge clk); #1;
        clear_logs();
        bus.wgt_base = wb; bus.img_base = ib; bus.num_steps = ns; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        st_cyc = cyc;
        bus.wgt_base = ~wb; bus.img_base = ~ib; bus.num_steps = 8'hA5;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (bus.done) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.instruction_out, bus.sel_out} !== 11'h0) begin
            bad++; $display("FAIL reset_instr: got %0h want 0", {bus.sel_out, bus.instruction_out});
        end
        total++;
        if ({bus.mem_rd_en, bus.mem_addr, bus.res_valid, bus.res_col, bus.busy, bus.done} !== 21'h0) begin
            bad++; $display("FAIL reset_ctrl: got %0h want 0",
                            {bus.mem_rd_en, bus.mem_addr, bus.res_valid, bus.res_col, bus.busy, bus.done});
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_wgt();
        int n;
        bit ok;
        n = 0;
        kick(16'h0300, 16'h0400, 8'd2);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.mem_rd_en) n++;
            if (n == 20) break;
        end
        rst = 1'b1;
        total++;
        if (n != 20) begin bad++; $display("FAIL midrst_reads: got %0d want 20", n); end
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.mem_rd_en, bus.mem_addr, bus.instruction_out, bus.sel_out, bus.res_valid, bus.busy, bus.done} !== 31'h0) begin
            bad++; $display("FAIL midrst_outputs: got %0h want 0",
                            {bus.mem_rd_en, bus.mem_addr, bus.instruction_out, bus.sel_out, bus.res_valid, bus.busy, bus.done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (done_rel_q.size() != 0 || bus.busy !== 1'b0 || rd_q.size() != 20) begin
            bad++; $display("FAIL midrst_abort: got done=%0d busy=%0b reads=%0d want 0 0 20",
                            done_rel_q.size(), bus.busy, rd_q.size());
        end
        kick(16'h0300, 16'h0400, 8'd0);
        wait_done(300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midrst_restart_done: got timeout want done"); end
        total++;
        if (rd_q.size() != 72 || rd_q[0] !== 16'h0300) begin
            bad++; $display("FAIL midrst_restart_addr: got n=%0d a0=%0h want 72 300",
                            rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx);
        end
    endtask

    task automatic test_wgt_load();
        bit ok;
        int e;
        logic [15:0] ea;
        logic [10:0] ei;
        kick(16'h0100, 16'h0040, 8'd0);
        wait_done(300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wgt_done: got timeout want done"); end
        total++;
        if (rd_q.size() != 72 || dat_q.size() != 72) begin
            bad++; $display("FAIL wgt_count: got rd=%0d dat=%0d want 72 72", rd_q.size(), dat_q.size());
        end
        e = 0;
        for (int i = 0; i < 72 && i < rd_q.size() && i < dat_q.size(); i++) begin
            ea = (i < 56) ? 16'h0100 + 16'(i) : 16'h0040 + 16'(i - 56);
            ei = (i < 56) ? 11'h440 : ((i < 64) ? 11'h080 : 11'h280);
            if (e == 0 && (rd_q[i] !== ea || dat_q[i] !== ei || dval_q[i] !== ea[7:0])) begin
                e = 1;
                total++; bad++;
                $display("FAIL wgt_seq[%0d]: got a=%0h i=%0h d=%0h want a=%0h i=%0h d=%0h",
                         i, rd_q[i], dat_q[i], dval_q[i], ea, ei, ea[7:0]);
            end
        end
        if (e == 0) total++;
        e = -1;
        for (int i = 0; i < 56; i++) if (e < 0 && wgt[i] !== 8'(i)) e = i;
        total++;
        if (e >= 0) begin bad++; $display("FAIL wgt_reg[%0d]: got %0h want %0h", e, wgt[e], 8'(e)); end
        total++;
        if (res_q.size() != 0 || ctl_q.size() != 0 || viol != 0) begin
            bad++; $display("FAIL wgt_noops: got res=%0d ops=%0d viol=%0d want 0 0 0", res_q.size(), ctl_q.size(), viol);
        end
        total++;
        if (done_rel_q.size() != 1 || done_rel_q[0] != 76 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL wgt_done_cycle: got n=%0d c=%0d busy=%0b want 1 76 0",
                            done_rel_q.size(), (done_rel_q.size() > 0) ? done_rel_q[0] : -1, bus.busy);
        end
    endtask

    task automatic test_steps3();
        bit ok;
        int e;
        int k;
        logic [10:0] ce [14] = '{11'h001, 11'h402, 11'h001, 11'h422, 11'h500,
                                 11'h001, 11'h402, 11'h001, 11'h422, 11'h500,
                                 11'h001, 11'h402, 11'h001, 11'h422};
        int cr [14] = '{76, 77, 80, 81, 84, 94, 95, 98, 99, 102, 112, 113, 116, 117};
        int rr [6]  = '{79, 83, 97, 101, 115, 119};
        kick(16'h0100, 16'h0200, 8'd3);
        wait_done(400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL s3_done: got timeout want done"); end
        total++;
        if (rd_q.size() != 88) begin bad++; $display("FAIL s3_reads: got %0d want 88", rd_q.size()); end
        e = -1;
        for (int i = 0; i < 32 && 56 + i < rd_q.size(); i++)
            if (e < 0 && rd_q[56+i] !== 16'h0200 + 16'(i)) e = i;
        total++;
        if (e >= 0) begin bad++; $display("FAIL s3_img_addr[%0d]: got %0h want %0h", e, rd_q[56+e], 16'h0200 + 16'(e)); end
        e = -1;
        for (int i = 56; i < dat_q.size(); i++)
            if (e < 0 && dat_q[i] !== ((i < 64) ? 11'h080 : 11'h280)) e = i;
        total++;
        if (e >= 0) begin bad++; $display("FAIL s3_img_instr[%0d]: got %0h want 080/280", e, dat_q[e]); end
        total++;
        if (ctl_q.size() != 14) begin
            bad++; $display("FAIL s3_ops_count: got %0d want 14", ctl_q.size());
        end else begin
            e = -1;
            for (int i = 0; i < 14; i++) if (e < 0 && (ctl_q[i] !== ce[i] || ctl_rel_q[i] != cr[i])) e = i;
            total++;
            if (e >= 0) begin
                bad++; $display("FAIL s3_ops[%0d]: got %0h@%0d want %0h@%0d", e, ctl_q[e], ctl_rel_q[e], ce[e], cr[e]);
            end
        end
        total++;
        if (res_q.size() != 6) begin
            bad++; $display("FAIL s3_res_count: got %0d want 6", res_q.size());
        end else begin
            e = -1;
            for (int i = 0; i < 6; i++) if (e < 0 && (res_q[i] !== 1'(i % 2) || res_rel_q[i] != rr[i])) e = i;
            total++;
            if (e >= 0) begin
                bad++; $display("FAIL s3_res[%0d]: got col=%0b@%0d want col=%0b@%0d", e, res_q[e], res_rel_q[e], 1'(e % 2), rr[e]);
            end
            k = 0; e = -1;
            for (int i = 0; i < ctl_q.size(); i++) begin
                if (ctl_q[i][4:0] == OP_CALC) begin
                    if (e < 0 && k < 6 && res_rel_q[k] - ctl_rel_q[i] != 2) e = k;
                    k++;
                end
            end
            total++;
            if (e >= 0 || k != 6) begin bad++; $display("FAIL s3_calc_lat: got res#%0d calcs=%0d want lat 2 calcs 6", e, k); end
        end
        total++;
        if (done_rel_q.size() != 1 || done_rel_q[0] != 120 || viol != 0) begin
            bad++; $display("FAIL s3_done_cycle: got n=%0d c=%0d viol=%0d want 1 120 0",
                            done_rel_q.size(), (done_rel_q.size() > 0) ? done_rel_q[0] : -1, viol);
        end
    endtask

    task automatic test_wrap_busy_start();
        bit ok;
        int e;
        kick(16'h0010, 16'hFFF8, 8'd1);
        repeat (10) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.wgt_base = 16'h7777; bus.img_base = 16'h5555; bus.num_steps = 8'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (55) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wrap_done: got timeout want done"); end
        total++;
        if (rd_q.size() != 72 || rd_q[0] !== 16'h0010) begin
            bad++; $display("FAIL wrap_reads: got n=%0d a0=%0h want 72 10", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx);
        end
        e = -1;
        for (int i = 0; i < 16 && 56 + i < rd_q.size(); i++)
            if (e < 0 && rd_q[56+i] !== 16'hFFF8 + 16'(i)) e = i;
        total++;
        if (e >= 0) begin bad++; $display("FAIL wrap_addr[%0d]: got %0h want %0h", e, rd_q[56+e], 16'hFFF8 + 16'(e)); end
        total++;
        if (done_rel_q.size() != 1 || done_rel_q[0] != 84 || res_q.size() != 2) begin
            bad++; $display("FAIL wrap_timing: got done=%0d res=%0d want 84 2",
                            (done_rel_q.size() > 0) ? done_rel_q[0] : -1, res_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n0;
        kick(16'h0100, 16'h0040, 8'd0);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.done) begin ok = 1'b1; break; end
        end
        bus.start = 1'b1; bus.wgt_base = 16'h0900;
        @(posedge clk); #1;
        bus.start = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_first_done: got timeout want done"); end
        n0 = rd_q.size();
        repeat (6) @(negedge clk);
        total++;
        if (rd_q.size() != n0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL b2b_start_on_done: got reads=%0d busy=%0b want %0d 0", rd_q.size(), bus.busy, n0);
        end
        kick(16'h0180, 16'h0060, 8'd0);
        wait_done(300, ok);
        total++;
        if (!ok || rd_q.size() != 72 || rd_q[0] !== 16'h0180 || done_rel_q.size() != 1 || done_rel_q[0] != 76) begin
            bad++; $display("FAIL b2b_second: got ok=%0b n=%0d a0=%0h done=%0d want 1 72 180 76", ok, rd_q.size(),
                            (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx, (done_rel_q.size() > 0) ? done_rel_q[0] : -1);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.wgt_base = '0;
        bus.img_base = '0;
        bus.num_steps = '0;
        test_reset();
        test_reset_mid_wgt();
        test_wgt_load();
        test_steps3();
        test_wrap_busy_start();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1);
    end

endmodule
